// File: rtl/cpu_decode_pkg.sv
// Shared types and constants for the RISC-V decode stage: opcode encodings,
// decoded class flags, illegal-instruction causes and buffer occupancy states.
package cpu_decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic load;
        logic store;
        logic op_imm;
        logic op;
        logic lui;
        logic auipc;
        logic branch;
        logic jal;
        logic jalr;
        logic system;
        logic fence;
        logic mul_div;
        logic word;
    } decode_ctrl_t;

    typedef enum logic [2:0] {
        ILL_NONE,
        ILL_QUADRANT,
        ILL_OPCODE,
        ILL_WORD_RV32,
        ILL_SHIFT,
        ILL_NO_M,
        ILL_NO_FENCE
    } illegal_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_MAIN,
        OCC_FULL
    } occ_e;

endpackage

// File: rtl/cpu_decode_if.sv
// Valid/ready instruction bus into the decode stage and decoded-entry bus out of it.
interface cpu_decode_if #(
    parameter int XLEN = 32
) ();
    import cpu_decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    decode_ctrl_t    out_ctrl;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_ctrl, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_ctrl, out_illegal
    );
endinterface

// File: rtl/cpu_decode_logic.sv
// Purely combinational RISC-V field extraction, immediate formation,
// class-flag decode and illegal-instruction detection.
module cpu_decode_logic
    import cpu_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int HAS_M        = 1,
    parameter int HAS_ZIFENCEI = 1
) (
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output decode_ctrl_t    ctrl,
    output logic            illegal
);
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt5, shamt6;
    logic [31:0]     u32;
    logic            is_shift, shift7_ok, shift6_ok;
    illegal_e        cls;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign u32    = {instr[31:12], 12'b0};
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {{(XLEN-31){u32[31]}}, u32[30:0]};
    assign shamt5 = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign shamt6 = {{(XLEN-6){1'b0}}, instr[25:20]};

    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign shift7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    assign shift6_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);

    // word and mul_div are modifiers riding on op_imm/op, not classes of their own
    always_comb begin
        ctrl = '0;
        imm  = '0;
        cls  = ILL_NONE;
        case (opcode)
            OPC_LOAD:   begin ctrl.load   = 1'b1; imm = imm_i; end
            OPC_STORE:  begin ctrl.store  = 1'b1; imm = imm_s; end
            OPC_LUI:    begin ctrl.lui    = 1'b1; imm = imm_u; end
            OPC_AUIPC:  begin ctrl.auipc  = 1'b1; imm = imm_u; end
            OPC_BRANCH: begin ctrl.branch = 1'b1; imm = imm_b; end
            OPC_JAL:    begin ctrl.jal    = 1'b1; imm = imm_j; end
            OPC_JALR:   begin ctrl.jalr   = 1'b1; imm = imm_i; end
            OPC_SYSTEM: begin ctrl.system = 1'b1; imm = imm_i; end
            OPC_FENCE: begin
                if (HAS_ZIFENCEI != 0) begin
                    ctrl.fence = 1'b1;
                    imm        = imm_i;
                end else begin
                    cls = ILL_NO_FENCE;
                end
            end
            OPC_OP_IMM: begin
                ctrl.op_imm = 1'b1;
                imm         = imm_i;
                if (is_shift) begin
                    if (XLEN == 64) begin
                        imm = shamt6;
                        if (!shift6_ok) cls = ILL_SHIFT;
                    end else begin
                        imm = shamt5;
                        if (!shift7_ok) cls = ILL_SHIFT;
                    end
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    cls = ILL_WORD_RV32;
                end else begin
                    ctrl.op_imm = 1'b1;
                    ctrl.word   = 1'b1;
                    imm         = imm_i;
                    if (is_shift) begin
                        imm = shamt5;
                        if (!shift7_ok) cls = ILL_SHIFT;
                    end
                end
            end
            OPC_OP, OPC_OP_32: begin
                ctrl.op   = 1'b1;
                ctrl.word = (opcode == OPC_OP_32);
                if (opcode == OPC_OP_32 && XLEN != 64) begin
                    cls = ILL_WORD_RV32;
                end else if (funct7 == FUNCT7_MULDIV) begin
                    if (HAS_M != 0) ctrl.mul_div = 1'b1;
                    else            cls = ILL_NO_M;
                end
            end
            default: cls = ILL_OPCODE;
        endcase
        if (instr[1:0] != 2'b11) cls = ILL_QUADRANT;
        if (cls != ILL_NONE) ctrl = '0;
        illegal = (cls != ILL_NONE);
    end
endmodule

// File: rtl/cpu_decode_stage.sv
// Decode pipeline stage: decodes on the input side and buffers results in a
// main entry plus a skid entry so in_ready can come straight from a flop.
module cpu_decode_stage
    import cpu_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int HAS_M        = 1,
    parameter int HAS_ZIFENCEI = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    cpu_decode_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        decode_ctrl_t    ctrl;
        logic            illegal;
    } entry_t;

    entry_t          dec_entry, main_q, main_next, skid_q, skid_next;
    occ_e            state, state_next;
    logic            in_ready_q, in_fire, out_fire;
    logic [6:0]      dec_opcode, dec_funct7;
    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic [2:0]      dec_funct3;
    logic [XLEN-1:0] dec_imm;
    decode_ctrl_t    dec_ctrl;
    logic            dec_illegal;

    cpu_decode_logic #(
        .XLEN         (XLEN),
        .HAS_M        (HAS_M),
        .HAS_ZIFENCEI (HAS_ZIFENCEI)
    ) u_logic (
        .instr   (bus.in_instr),
        .opcode  (dec_opcode),
        .rd      (dec_rd),
        .funct3  (dec_funct3),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .funct7  (dec_funct7),
        .imm     (dec_imm),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_entry.pc      = bus.in_pc;
        dec_entry.opcode  = dec_opcode;
        dec_entry.rd      = dec_rd;
        dec_entry.funct3  = dec_funct3;
        dec_entry.rs1     = dec_rs1;
        dec_entry.rs2     = dec_rs2;
        dec_entry.funct7  = dec_funct7;
        dec_entry.imm     = dec_imm;
        dec_entry.ctrl    = dec_ctrl;
        dec_entry.illegal = dec_illegal;
    end

    // A flushed cycle never accepts, so the incoming word is silently dropped
    assign in_fire  = bus.in_valid && in_ready_q && !flush;
    assign out_fire = (state != OCC_EMPTY) && bus.out_ready;

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_next  = dec_entry;
                        state_next = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (out_fire) begin
                        if (in_fire) main_next  = dec_entry;
                        else         state_next = OCC_EMPTY;
                    end else if (in_fire) begin
                        skid_next  = dec_entry;
                        state_next = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_next  = skid_q;
                        state_next = OCC_MAIN;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= OCC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            main_q     <= main_next;
            skid_q     <= skid_next;
            in_ready_q <= (state_next != OCC_FULL);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state != OCC_EMPTY);
    assign bus.out_pc      = main_q.pc;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_funct3  = main_q.funct3;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_funct7  = main_q.funct7;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_ctrl    = main_q.ctrl;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: doc/cpu_decode_stage.md
CPU_DECODE_STAGE -- requirements
Module: cpu_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter HAS_M, default 1, M-extension decode enable.
REQ-003 SHALL have parameter HAS_ZIFENCEI, default 1, FENCE/FENCE.I decode enable.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, discard all held and incoming instructions.
REQ-007 SHALL have port in_valid, input, 1, upstream instruction present.
REQ-008 SHALL have port in_ready, output, 1, stage accepts in_instr this cycle.
REQ-009 SHALL have port in_instr, input, 32, raw instruction word.
REQ-010 SHALL have port in_pc, input, XLEN, instruction address.
REQ-011 SHALL have port out_valid, output, 1, decoded entry presented.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes the entry.
REQ-013 SHALL have port out_pc, output, XLEN, pc of presented entry.
REQ-014 SHALL have ports out_opcode/out_rd/out_funct3/out_rs1/out_rs2/out_funct7, output, 7/5/3/5/5/7, instruction fields.
REQ-015 SHALL have port out_imm, output, XLEN, sign- or zero-extended immediate.
REQ-016 SHALL have port out_ctrl, output, decode_ctrl_t, class flags: load, store, op_imm, op, lui, auipc, branch, jal, jalr, system, fence, mul_div, word.
REQ-017 SHALL have port out_illegal, output, 1, entry is an illegal instruction.

Function
REQ-018 SHALL transfer in when in_valid&&in_ready and out when out_valid&&out_ready.
REQ-019 SHALL register decode results; an accepted instruction SHALL appear on out_* no earlier than the next cycle.
REQ-020 SHALL hold two entries (main + skid); in_ready SHALL be a register output, deasserted only when both entries are full.
REQ-021 SHALL sustain one instruction per cycle when out_ready stays high.
REQ-022 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-023 SHALL deliver entries strictly in acceptance order.
REQ-024 SHALL treat a simultaneous in-transfer and out-transfer on a full main entry as pass-through, with no skid use.
REQ-025 SHALL, on flush, empty both entries next cycle (out_valid=0, in_ready=1) and drop any same-cycle input transfer.
REQ-026 SHALL give precedence to reset_n over flush.
REQ-027 SHALL form immediates as: I-type sign-extend [31:20]; S, B, J per RISC-V; U = [31:12]<<12 sign-extended from bit 31 to XLEN.
REQ-028 SHALL zero-extend shift amounts: 6 bits [25:20] for OP-IMM when XLEN=64, else 5 bits [24:20].
REQ-029 SHALL assert ctrl.word for opcodes 0011011/0111011, only when XLEN=64.
REQ-030 SHALL assert exactly one class flag for legal instructions; mul_div SHALL accompany op.
REQ-031 SHALL flag illegal, with all class flags 0, when any of these holds: in_instr[1:0]!=2'b11; opcode unknown; W-opcodes with XLEN=32; shift funct7 upper bits not 0000000/0100000 (RV64: [31:26] not 000000/010000); funct7=0000001 with HAS_M=0; opcode 0001111 with HAS_ZIFENCEI=0.

Reset
REQ-032 SHALL, while reset_n=0 at a clock edge, clear both entries and set out_valid=0, in_ready=1, and every out_* data field to 0.
REQ-033 SHALL discard in-flight entries when reset occurs mid-stream; the first post-reset accept SHALL be the first output.

Structure
REQ-034 SHALL define decode_ctrl_t, the opcode localparams and the illegal-class enum in package cpu_decode_pkg.
REQ-035 SHALL place the combinational field/immediate/ctrl/illegal logic in sub-module cpu_decode_logic (parameters XLEN, HAS_M, HAS_ZIFENCEI), instantiated once on the input side.

Verification
REQ-036 SHALL check: 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, rd=1, imm=all ones, ctrl.op_imm=1.
REQ-037 SHALL check: 0x03F09093 (slli x1,x1,63) -> XLEN=64: imm=63, legal; XLEN=32: out_illegal=1.
REQ-038 SHALL check: out_ready=0 with three back-to-back inputs -> in_ready=0 after two accepts; after release, all three emerge in order with unchanged pc.
REQ-039 SHALL check: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
REQ-040 SHALL check: 0x02208033 (mul) with HAS_M=0 -> out_illegal=1; with HAS_M=1 -> ctrl.op=1 and ctrl.mul_div=1.
REQ-041 SHALL check: reset_n=0 for one cycle mid-stream -> all outputs zero and in_ready=1, then clean restart.
